// File: rtl/instr_mem_seq.sv
// Byte-organised instruction store with a registered valid/ready fetch port.
// Optional macro IM_ALIGN_CHECK_EN enables misalignment flagging and NOP fill.
module instr_mem_seq #(
    parameter int MEM_BYTES  = 128,
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_instr,
    output logic             rsp_oob,
    output logic             rsp_misalign,
    input  logic             ld_en,
    input  logic [31:0]      ld_addr,
    input  logic [7:0]       ld_data,
    output logic [CNT_W-1:0] fetch_cnt
);

    localparam int AW = $clog2(MEM_BYTES);

    typedef enum logic {EMPTY, FULL} state_e;

    logic [7:0] InstrMem [MEM_BYTES];

    state_e           state_q, state_d;
    logic [31:0]      instr_q, instr_d;
    logic             oob_q, oob_d;
    logic             mis_q, mis_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic [AW-1:0]    idx0, idx1, idx2, idx3;
    logic [31:0]      word;
    logic             unused_ld;

    assign unused_ld = ^ld_addr[31:AW];

    assign req_ready = (state_q == EMPTY) || rsp_ready;
    assign accept    = req_valid && req_ready;

    // Index arithmetic is AW bits wide so the four bytes wrap naturally.
    always_comb begin
        idx0 = req_addr[AW-1:0];
        idx1 = idx0 + AW'(1);
        idx2 = idx0 + AW'(2);
        idx3 = idx0 + AW'(3);
        if (BIG_ENDIAN)
            word = {InstrMem[idx0], InstrMem[idx1],
                    InstrMem[idx2], InstrMem[idx3]};
        else
            word = {InstrMem[idx3], InstrMem[idx2],
                    InstrMem[idx1], InstrMem[idx0]};
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        oob_d   = oob_q;
        mis_d   = mis_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = FULL;
            oob_d   = |req_addr[31:AW];
`ifdef IM_ALIGN_CHECK_EN
            mis_d   = (req_addr[1:0] != 2'b00);
            instr_d = mis_d ? 32'h0000_0000 : word;
`else
            mis_d   = 1'b0;
            instr_d = word;
`endif
            if (cnt_q != {CNT_W{1'b1}})
                cnt_d = cnt_q + CNT_W'(1);
        end else if (state_q == FULL && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            instr_q <= 32'h0000_0000;
            oob_q   <= 1'b0;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            oob_q   <= oob_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    // Array is deliberately not reset; the fetch path sees the old byte on a same-edge load.
    always_ff @(posedge clk) begin
        if (ld_en)
            InstrMem[ld_addr[AW-1:0]] <= ld_data;
    end

    assign rsp_valid    = (state_q == FULL);
    assign rsp_instr    = instr_q;
    assign rsp_oob      = oob_q;
    assign rsp_misalign = mis_q;
    assign fetch_cnt    = cnt_q;

endmodule

// File: tb/tb_instr_mem_seq.sv
// Directed bench for instr_mem_seq: big/little endian and 2-bit counter instances
// share one stimulus stream.
module tb_instr_mem_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        rsp_ready;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [7:0]  ld_data;

    logic        req_ready, rsp_valid, rsp_oob, rsp_misalign;
    logic [31:0] rsp_instr;
    logic [15:0] fetch_cnt;

    logic        le_req_ready, le_rsp_valid, le_rsp_oob, le_rsp_misalign;
    logic [31:0] le_rsp_instr;
    logic [15:0] le_fetch_cnt;

    logic        c2_req_ready, c2_rsp_valid, c2_rsp_oob, c2_rsp_misalign;
    logic [31:0] c2_rsp_instr;
    logic [1:0]  c2_fetch_cnt;

    int total = 0;
    int bad = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    instr_mem_seq #(.MEM_BYTES(128), .BIG_ENDIAN(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
        .rsp_oob(rsp_oob), .rsp_misalign(rsp_misalign),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .fetch_cnt(fetch_cnt)
    );

    instr_mem_seq #(.MEM_BYTES(128), .BIG_ENDIAN(1'b0), .CNT_W(16)) dut_le (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(le_req_ready), .req_addr(req_addr),
        .rsp_valid(le_rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(le_rsp_instr),
        .rsp_oob(le_rsp_oob), .rsp_misalign(le_rsp_misalign),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .fetch_cnt(le_fetch_cnt)
    );

    instr_mem_seq #(.MEM_BYTES(128), .BIG_ENDIAN(1'b1), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(c2_req_ready), .req_addr(req_addr),
        .rsp_valid(c2_rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(c2_rsp_instr),
        .rsp_oob(c2_rsp_oob), .rsp_misalign(c2_rsp_misalign),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .fetch_cnt(c2_fetch_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        req_valid = 1'b1; req_addr = a; rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        exp_cnt++;
    endtask

    task automatic drain();
        req_valid = 1'b0; rsp_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'd0; rsp_ready = 1'b0;
        ld_en = 1'b0; ld_addr = 32'd0; ld_data = 8'd0;
        #12;
        total++;
        if (rsp_valid !== 1'b0 || rsp_instr !== 32'h0 || rsp_oob !== 1'b0 ||
            rsp_misalign !== 1'b0 || fetch_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_state got v=%b i=%h o=%b m=%b c=%0d exp 0", rsp_valid,
                     rsp_instr, rsp_oob, rsp_misalign, fetch_cnt);
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_req_ready got %b exp 1", req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic preload();
        load(32'd0, 8'h12); load(32'd1, 8'h34); load(32'd2, 8'h56); load(32'd3, 8'h78);
        load(32'd4, 8'h44); load(32'd5, 8'h55); load(32'd6, 8'h66); load(32'd7, 8'h77);
        load(32'd8, 8'h01); load(32'd9, 8'h09); load(32'd10, 8'h0A); load(32'd11, 8'h0B);
        load(32'd124, 8'hAA); load(32'd125, 8'hBB);
        load(32'd126, 8'hCC); load(32'd127, 8'hDD);
    endtask

    task automatic test_basic();
        fetch(32'd0);
        total++;
        if (rsp_valid !== 1'b1 || rsp_instr !== 32'h12345678) begin
            bad++;
            $display("FAIL basic_be got v=%b i=%h exp v=1 i=12345678", rsp_valid, rsp_instr);
        end
        total++;
        if (le_rsp_instr !== 32'h78563412) begin
            bad++;
            $display("FAIL basic_le got %h exp 78563412", le_rsp_instr);
        end
        total++;
        if (fetch_cnt !== 16'd1 || rsp_oob !== 1'b0) begin
            bad++;
            $display("FAIL basic_cnt got c=%0d o=%b exp c=1 o=0", fetch_cnt, rsp_oob);
        end
    endtask

    task automatic test_wrap();
        fetch(32'd252);
        total++;
        if (rsp_instr !== 32'hAABBCCDD || rsp_oob !== 1'b1) begin
            bad++;
            $display("FAIL oob_252 got i=%h o=%b exp i=aabbccdd o=1", rsp_instr, rsp_oob);
        end
        total++;
        if (le_rsp_instr !== 32'hDDCCBBAA) begin
            bad++;
            $display("FAIL oob_252_le got %h exp ddccbbaa", le_rsp_instr);
        end
        fetch(32'd126);
`ifdef IM_ALIGN_CHECK_EN
        total++;
        if (rsp_instr !== 32'h0 || rsp_misalign !== 1'b1 || rsp_oob !== 1'b0) begin
            bad++;
            $display("FAIL wrap_126 got i=%h m=%b o=%b exp 0 1 0", rsp_instr, rsp_misalign,
                     rsp_oob);
        end
`else
        total++;
        if (rsp_instr !== 32'hCCDD1234 || rsp_oob !== 1'b0) begin
            bad++;
            $display("FAIL wrap_126 got i=%h o=%b exp i=ccdd1234 o=0", rsp_instr, rsp_oob);
        end
`endif
    endtask

    task automatic test_misalign();
        fetch(32'd5);
`ifdef IM_ALIGN_CHECK_EN
        total++;
        if (rsp_misalign !== 1'b1 || rsp_instr !== 32'h0) begin
            bad++;
            $display("FAIL misalign_5 got m=%b i=%h exp m=1 i=0", rsp_misalign, rsp_instr);
        end
`else
        total++;
        if (rsp_misalign !== 1'b0 || rsp_instr !== 32'h55667701) begin
            bad++;
            $display("FAIL misalign_5 got m=%b i=%h exp m=0 i=55667701", rsp_misalign,
                     rsp_instr);
        end
`endif
        fetch(32'd4);
        total++;
        if (rsp_misalign !== 1'b0 || rsp_instr !== 32'h44556677) begin
            bad++;
            $display("FAIL aligned_4 got m=%b i=%h exp m=0 i=44556677", rsp_misalign,
                     rsp_instr);
        end
    endtask

    task automatic test_backpressure();
        drain();
        req_valid = 1'b1; req_addr = 32'd0; rsp_ready = 1'b0;
        tick();
        exp_cnt++;
        total++;
        if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_full got v=%b rdy=%b exp v=1 rdy=0", rsp_valid, req_ready);
        end
        for (int i = 0; i < 5; i++) begin
            req_addr = (i % 2 == 0) ? 32'd4 : 32'd252;
            tick();
            total++;
            if (rsp_instr !== 32'h12345678 || rsp_valid !== 1'b1 || rsp_oob !== 1'b0 ||
                req_ready !== 1'b0 || fetch_cnt !== 16'(exp_cnt)) begin
                bad++;
                $display("FAIL bp_hold%0d got i=%h v=%b o=%b rdy=%b c=%0d exp 12345678 1 0 0 %0d",
                         i, rsp_instr, rsp_valid, rsp_oob, req_ready, fetch_cnt, exp_cnt);
            end
        end
        req_addr = 32'd4; rsp_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_passthru got %b exp 1", req_ready);
        end
        tick();
        exp_cnt++;
        total++;
        if (rsp_valid !== 1'b1 || rsp_instr !== 32'h44556677) begin
            bad++;
            $display("FAIL b2b_first got v=%b i=%h exp 1 44556677", rsp_valid, rsp_instr);
        end
        req_addr = 32'd0;
        tick();
        exp_cnt++;
        req_valid = 1'b0;
        total++;
        if (rsp_valid !== 1'b1 || rsp_instr !== 32'h12345678 ||
            fetch_cnt !== 16'(exp_cnt)) begin
            bad++;
            $display("FAIL b2b_second got v=%b i=%h c=%0d exp 1 12345678 %0d", rsp_valid,
                     rsp_instr, fetch_cnt, exp_cnt);
        end
        drain();
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain got v=%b exp 0", rsp_valid);
        end
    endtask

    task automatic test_collision();
        ld_en = 1'b1; ld_addr = 32'd8; ld_data = 8'hFF;
        fetch(32'd8);
        ld_en = 1'b0;
        total++;
        if (rsp_instr !== 32'h01090A0B) begin
            bad++;
            $display("FAIL collide_old got %h exp 01090a0b", rsp_instr);
        end
        fetch(32'd8);
        total++;
        if (rsp_instr !== 32'hFF090A0B) begin
            bad++;
            $display("FAIL collide_new got %h exp ff090a0b", rsp_instr);
        end
    endtask

    task automatic test_reset_midop();
        drain();
        req_valid = 1'b1; req_addr = 32'd4; rsp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        total++;
        if (rsp_valid !== 1'b1) begin
            bad++;
            $display("FAIL midop_full got %b exp 1", rsp_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (rsp_valid !== 1'b0 || fetch_cnt !== 16'd0 || rsp_instr !== 32'h0 ||
            req_ready !== 1'b1 || c2_fetch_cnt !== 2'd0) begin
            bad++;
            $display("FAIL midop_reset got v=%b c=%0d i=%h rdy=%b c2=%0d exp 0 0 0 1 0",
                     rsp_valid, fetch_cnt, rsp_instr, req_ready, c2_fetch_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        fetch(32'd0);
        total++;
        if (rsp_instr !== 32'h12345678 || fetch_cnt !== 16'd1) begin
            bad++;
            $display("FAIL mem_intact got i=%h c=%0d exp 12345678 1", rsp_instr, fetch_cnt);
        end
        for (int i = 0; i < 4; i++) fetch(32'(i * 4));
        total++;
        if (c2_fetch_cnt !== 2'd3 || fetch_cnt !== 16'd5) begin
            bad++;
            $display("FAIL cnt_sat got c2=%0d c=%0d exp 3 5", c2_fetch_cnt, fetch_cnt);
        end
    endtask

    initial begin
        test_reset();
        preload();
        test_basic();
        test_wrap();
        test_misalign();
        test_backpressure();
        test_collision();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_mem_seq.md
# instr_mem_seq

Synchronous, parametrised successor to the combinational instruction memory: a byte-organised instruction store with a registered, valid/ready-handshaked fetch port, a byte-wide program-load write port, selectable byte order and address-fault flags. It sits between the PC/fetch stage and the decode stage of the multi-cycle and pipelined CPUs. The array keeps the name `InstrMem`, so testbenches can still preload it with `$readmemh`.

## Interface
- `MEM_BYTES`, 128: array size in bytes; power of two, ≥4.
- `BIG_ENDIAN`, 1: 1 = byte at addr is instr[31:24]; 0 = byte at addr is instr[7:0].
- `CNT_W`, 16: width of the fetch counter.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: fetch request.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_addr` in 32: byte address of the fetch.
- `rsp_valid` out 1: response held in the output register.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_instr` out 32: fetched instruction word.
- `rsp_oob` out 1: `req_addr` ≥ `MEM_BYTES`.
- `rsp_misalign` out 1: `req_addr[1:0] != 0` (present only with the macro; otherwise tied 0).
- `ld_en` in 1: program-load byte write.
- `ld_addr` in 32: load byte address; uses the low log2(MEM_BYTES) bits.
- `ld_data` in 8: load byte.
- `fetch_cnt` out CNT_W: number of accepted fetches; saturates at all-ones.

## Operation
- Index: idx = `req_addr[AW-1:0]`, with AW = log2(MEM_BYTES). The four bytes are idx, idx+1, idx+2, idx+3, each taken modulo MEM_BYTES (wrap-around).
- Byte order follows `BIG_ENDIAN`. With `BIG_ENDIAN`=1: {M[idx], M[idx+1], M[idx+2], M[idx+3]}.
- One-entry output buffer with two states:
  - EMPTY: `rsp_valid`=0.
  - FULL: `rsp_valid`=1.
- Transitions:
  - EMPTY + accept → FULL.
  - FULL + `rsp_ready` with no accept → EMPTY.
  - FULL + `rsp_ready` + accept → stays FULL; the register is loaded with the new word.
  - FULL + !`rsp_ready` → holds. `rsp_instr` and the flags are stable.
- `req_ready` = !`rsp_valid` || `rsp_ready` (combinational pass-through of `rsp_ready`).
- `rsp_oob`: registered with the word. The returned data is still the wrapped word.
- Load port:
  - When `ld_en`=1, M[`ld_addr` mod MEM_BYTES] ← `ld_data` on the rising edge.
  - The load port is independent of the handshake.
- Read/write same cycle, same byte: the fetch returns the old byte (read-before-write).
- `fetch_cnt` increments by 1 on every accept and stops at 2^CNT_W−1.

## Timing
- Latency: a request accepted at edge N produces its response visible after edge N (`rsp_valid`=1 from cycle N+1).
- Throughput: 1 fetch/cycle while `rsp_ready`=1.
- Reset (asynchronous assert, synchronous-safe deassert by the system):
  - `rsp_valid`=0, `rsp_instr`=0, `rsp_oob`=0, `rsp_misalign`=0, `fetch_cnt`=0.
  - `req_ready`=1 after reset.
  - Memory contents are NOT reset.
- Reset mid-operation: a pending response is dropped. No partial state survives. Loads in progress on the reset edge are not guaranteed.
- No combinational path from `req_addr` to any output.

## Configuration
- Macro: `IM_ALIGN_CHECK_EN`.
- Defined:
  - `rsp_misalign` is driven as registered `req_addr[1:0]!=0`.
  - On misalignment, `rsp_instr` is forced to 32'h00000000 (NOP) instead of the byte-gathered word.
  - `rsp_oob` is still reported.
- Undefined:
  - `rsp_misalign` is constant 0.
  - Unaligned fetches return the four consecutive bytes (with wrap) as described under Operation.

## Test plan
- Reset then fetch: preload M[0..3]=12,34,56,78, BIG_ENDIAN=1, fetch addr 0 → next cycle `rsp_valid`=1, `rsp_instr`=32'h12345678, `fetch_cnt`=1. With BIG_ENDIAN=0 the same preload → 32'h78563412.
- Wrap/OOB: MEM_BYTES=128, M[124..127]=AA,BB,CC,DD, fetch addr 252 → `rsp_instr`=32'hAABBCCDD, `rsp_oob`=1. Without the macro, fetch addr 126 with M[0]=11, M[1]=22 → 32'hCCDD1122.
- Backpressure: hold `rsp_ready`=0 with a response pending → `req_ready`=0, and `rsp_instr` is unchanged for 5 cycles while `req_addr` toggles. Raise `rsp_ready` together with a new request → back-to-back responses, no bubble.
- Load collision: M[8]=01 preloaded, `ld_en` to addr 8 with 8'hFF in the same cycle as a fetch of 8 → response byte 01. A refetch of 8 → FF.
- Misalign (macro defined): fetch addr 5 → `rsp_misalign`=1, `rsp_instr`=0. Addr 4 → `rsp_misalign`=0.
- Reset mid-operation: assert `rst_n`=0 while FULL → `rsp_valid` drops immediately (asynchronous) and `fetch_cnt`=0. Memory preload is intact after release. CNT_W=2: 5 accepts → `fetch_cnt`=3 (saturated).
